// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg: shared UART byte width, character and arbiter state constants
// Revision: 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if: requester handshakes and transmitter link of the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if;

  logic [uart_pkg::BYTE_W-1:0] req0_data;
  logic                        req0_valid;
  logic                        req0_last;
  logic                        req0_ready;

  logic [uart_pkg::BYTE_W-1:0] req1_data;
  logic                        req1_valid;
  logic                        req1_last;
  logic                        req1_ready;

  logic [uart_pkg::BYTE_W-1:0] tx_data;
  logic                        tx_start;
  logic                        tx_busy;

  logic [1:0]                  grant;
  logic                        timeout_err;

  // Environment side: requesters plus the UART transmitter
  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    output tx_busy,
    input  req0_ready, req1_ready,
    input  tx_data, tx_start, grant, timeout_err
  );

  // Arbiter side
  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    input  tx_busy,
    output req0_ready, req1_ready,
    output tx_data, tx_start, grant, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2: combinational two-request round-robin pick, rr_ptr wins a tie
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter logic [15:0] HOLD_TIMEOUT = 16'd50000,
  parameter logic [3:0]  ACK_WAIT     = 4'd8
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              last_q, last_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]        ack_cnt_q, ack_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic [1:0]        pick;
  logic              ready0, ready1;
  logic              handshake;
  logic              owner_valid;
  logic [BYTE_W-1:0] owner_data;
  logic              owner_last;

  rr_arb2 u_rr_arb2 (
    .req    ({bus.req1_valid, bus.req0_valid}),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick)
  );

  assign ready0      = (state_q == ISSUE) && grant_q[0] && !bus.tx_busy;
  assign ready1      = (state_q == ISSUE) && grant_q[1] && !bus.tx_busy;
  assign handshake   = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);

  assign owner_valid = grant_q[1] ? bus.req1_valid : (grant_q[0] && bus.req0_valid);
  assign owner_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
  assign owner_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    last_d        = last_q;
    hold_cnt_d    = hold_cnt_q;
    ack_cnt_d     = ack_cnt_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_d    = pick;
          hold_cnt_d = 16'd0;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (handshake) begin
          tx_data_d  = owner_data;
          tx_start_d = 1'b1;
          last_d     = owner_last;
          hold_cnt_d = 16'd0;
          ack_cnt_d  = 4'd0;
          state_d    = WAIT_ACK;
        end else if (hold_cnt_q >= HOLD_TIMEOUT - 16'd1) begin
          // Stalled owner: release the grant and hand priority to the other port
          timeout_err_d = 1'b1;
          grant_d       = 2'b00;
          rr_ptr_d      = grant_q[0];
          hold_cnt_d    = 16'd0;
          state_d       = IDLE;
        end else if (!owner_valid && (hold_cnt_q != 16'hFFFF)) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end

      WAIT_ACK: begin
        // A transmitter that never raises busy must not deadlock the arbiter
        if (bus.tx_busy || (ack_cnt_q == ACK_WAIT)) begin
          state_d = WAIT_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            grant_d  = 2'b00;
            rr_ptr_d = grant_q[0];
            state_d  = IDLE;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      rr_ptr_q      <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      last_q        <= 1'b0;
      hold_cnt_q    <= 16'd0;
      ack_cnt_q     <= 4'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      last_q        <= last_d;
      hold_cnt_q    <= hold_cnt_d;
      ack_cnt_q     <= ack_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant       = grant_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam logic [15:0] HT = 16'd40;
  localparam logic [3:0]  AW = 4'd8;

  typedef struct packed { logic [7:0] data; logic last; } byte_t;
  typedef struct packed { logic [7:0] data; logic [1:0] grant; } exp_t;
  typedef struct { logic [1:0] mask; logic [7:0] d0; logic [7:0] d1; logic [1:0] first; } vec_t;

  logic clk;
  logic rst_n;
  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.HOLD_TIMEOUT(HT), .ACK_WAIT(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    errors = 0;
  int    checks = 0;
  byte_t q0[$];
  byte_t q1[$];
  exp_t  sb[$];
  int    gap_q[$];
  logic  hs0 = 1'b0, hs1 = 1'b0;
  logic  dead = 1'b0;
  int    busy_len = 6;
  int    busy_cnt = 0;
  int    cyc = 0, starts = 0, last_start_cyc = 0;
  int    to_pulses = 0, own_viol = 0, r1_seen = 0;
  vec_t  vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push0(input logic [7:0] d, input logic l); q0.push_back({d, l}); endtask
  task automatic push1(input logic [7:0] d, input logic l); q1.push_back({d, l}); endtask
  task automatic push_exp(input logic [7:0] d, input logic [1:0] g); sb.push_back({d, g}); endtask

  // Environment: transmitter busy model, requester drivers, scoreboard monitor
  initial begin
    exp_t e;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
    bus.tx_busy    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.tx_start === 1'b1) begin
        starts++;
        gap_q.push_back(cyc - last_start_cyc);
        last_start_cyc = cyc;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_start: got data 0x%0h grant %b, expected no start", bus.tx_data, bus.grant);
        end else begin
          e = sb.pop_front();
          check("tx_data", {24'd0, bus.tx_data}, {24'd0, e.data});
          check("grant_at_start", {30'd0, bus.grant}, {30'd0, e.grant});
        end
      end
      if (bus.timeout_err === 1'b1) begin
        to_pulses++;
        check("grant_on_timeout", {30'd0, bus.grant}, 32'd0);
      end
      if (!rst_n) begin
        hs0 = 1'b0; hs1 = 1'b0; busy_cnt = 0;
        bus.tx_busy = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) bus.tx_busy = 1'b0;
        end
        if (bus.tx_start === 1'b1 && !dead) begin
          bus.tx_busy = 1'b1;
          busy_cnt    = busy_len;
        end
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        bus.req0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin bus.req0_data = q0[0].data; bus.req0_last = q0[0].last; end
        bus.req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin bus.req1_data = q1[0].data; bus.req1_last = q1[0].last; end
        #1;
        hs0 = bus.req0_valid && bus.req0_ready;
        hs1 = bus.req1_valid && bus.req1_ready;
        if ((bus.req0_ready && !bus.grant[0]) || (bus.req1_ready && !bus.grant[1])) own_viol++;
        if (bus.req1_ready) r1_seen++;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (n < 3000 && !(q0.size() == 0 && q1.size() == 0 && sb.size() == 0 &&
                             bus.grant == 2'b00 && !bus.tx_busy));
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_idle: got %0d bytes still expected, required 0 within budget", name, sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int target, input string name);
    int n;
    n = 0;
    while (starts < target && n < 500) begin @(posedge clk); #1; n++; end
    if (starts < target) begin
      checks++; errors++;
      $display("FAIL %s: got %0d starts, required %0d", name, starts, target);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete(); sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int base, bad, tb0;
    vec_t v;

    vecs[0] = '{2'b01, 8'h41, 8'h00, 2'b01};
    vecs[1] = '{2'b10, 8'h00, 8'h42, 2'b10};
    vecs[2] = '{2'b11, 8'h61, 8'h62, 2'b01};
    vecs[3] = '{2'b11, 8'h63, 8'h64, 2'b01};
    vecs[4] = '{2'b01, 8'h65, 8'h00, 2'b01};
    vecs[5] = '{2'b11, 8'h66, 8'h67, 2'b10};
    vecs[6] = '{2'b10, 8'h00, 8'h68, 2'b10};
    vecs[7] = '{2'b11, 8'h69, 8'h6A, 2'b01};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant",       {30'd0, bus.grant}, 32'd0);
    check("rst_tx_start",    {31'd0, bus.tx_start}, 32'd0);
    check("rst_tx_data",     {24'd0, bus.tx_data}, 32'd0);
    check("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    check("rst_ready",       {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte on port 0
    busy_len = 20; base = starts; r1_seen = 0;
    push0(8'h41, 1'b1); push_exp(8'h41, 2'b01);
    wait_idle("single");
    check("single_grant_released", {30'd0, bus.grant}, 32'd0);
    check("single_starts", starts - base, 32'd1);
    check("single_req1_ready_seen", r1_seen, 32'd0);

    // Tie after reset, then a second tie that port 1 must win
    do_reset();
    busy_len = 6; base = starts;
    push0("a", 1'b0); push0("b", 1'b0); push0("c", 1'b1); push0("x", 1'b1);
    push1("H", 1'b0); push1("I", 1'b0); push1(CHAR_CR, 1'b0); push1(CHAR_LF, 1'b1);
    push_exp("a", 2'b01); push_exp("b", 2'b01); push_exp("c", 2'b01);
    push_exp("H", 2'b10); push_exp("I", 2'b10); push_exp(CHAR_CR, 2'b10); push_exp(CHAR_LF, 2'b10);
    push_exp("x", 2'b01);
    wait_idle("tie");
    check("tie_starts", starts - base, 32'd8);

    // Port 0 arrives while port 1 is mid-packet
    base = starts;
    push1("H", 1'b0); push1("I", 1'b0); push1(CHAR_CR, 1'b0); push1(CHAR_LF, 1'b1);
    push_exp("H", 2'b10); push_exp("I", 2'b10); push_exp(CHAR_CR, 2'b10); push_exp(CHAR_LF, 2'b10);
    wait_start(base + 1, "midpkt_first_start");
    push0("Z", 1'b1); push_exp("Z", 2'b01);
    wait_idle("midpkt");
    check("midpkt_starts", starts - base, 32'd5);
    check("midpkt_owner_violations", own_viol, 32'd0);

    // Owner stalls mid-packet; hold timeout releases it
    base = starts; tb0 = to_pulses;
    push0("1", 1'b0); push0("2", 1'b0);
    push_exp("1", 2'b01); push_exp("2", 2'b01);
    wait_start(base + 2, "stall_second_start");
    push1("P", 1'b1); push_exp("P", 2'b10);
    wait_idle("stall");
    check("stall_timeout_pulses", to_pulses - tb0, 32'd1);
    check("stall_starts", starts - base, 32'd3);
    check("stall_owner_violations", own_viol, 32'd0);

    // Dead transmitter: bytes advance on the ack timeout
    dead = 1'b1; gap_q.delete(); base = starts;
    push0("d", 1'b0); push0("e", 1'b0); push0("f", 1'b1);
    push_exp("d", 2'b01); push_exp("e", 2'b01); push_exp("f", 2'b01);
    wait_idle("dead");
    check("dead_starts", gap_q.size(), 32'd3);
    if (gap_q.size() == 3) begin
      check("dead_gap1", gap_q[1], 32'(AW) + 32'd3);
      check("dead_gap2", gap_q[2], 32'(AW) + 32'd3);
    end
    dead = 1'b0;

    // Reset while waiting for the transmitter to finish
    busy_len = 20; base = starts;
    push0("Q", 1'b1); push_exp("Q", 2'b01);
    wait_start(base + 1, "rstmid_start");
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_grant",       {30'd0, bus.grant}, 32'd0);
    check("rstmid_tx_start",    {31'd0, bus.tx_start}, 32'd0);
    check("rstmid_tx_data",     {24'd0, bus.tx_data}, 32'd0);
    check("rstmid_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    check("rstmid_ready",       {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    q0.delete(); q1.delete(); sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = starts; bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.grant != 2'b00) bad++;
    end
    check("rstmid_no_start", starts - base, 32'd0);
    check("rstmid_grant_cycles", bad, 32'd0);

    // Table-driven arbitration sequence from a fresh reset
    do_reset();
    busy_len = 4;
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      base = starts;
      if (v.mask[0]) push0(v.d0, 1'b1);
      if (v.mask[1]) push1(v.d1, 1'b1);
      if (v.first == 2'b01) begin
        if (v.mask[0]) push_exp(v.d0, 2'b01);
        if (v.mask[1]) push_exp(v.d1, 2'b10);
      end else begin
        if (v.mask[1]) push_exp(v.d1, 2'b10);
        if (v.mask[0]) push_exp(v.d0, 2'b01);
      end
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_starts", i), starts - base, $countones(v.mask));
    end
    check("final_owner_violations", own_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
